// File: rtl/psram_apb_ctrl.sv
// psram_apb_ctrl: APB slave that turns each access into one CE-framed QPI
// PSRAM transaction (command, 24-bit quad address, dummy for reads, quad data).
// sck runs at clock/2; every sck period is one low cycle followed by one high cycle.
// Optional feature macro: PSRAM_STRB_SPLIT_EN -- when defined, a non-contiguous
// write strobe is issued as one CE frame per contiguous byte run; when undefined
// such a strobe is rejected with pslverr and no PSRAM activity.
`timescale 1ns/1ps
module psram_apb_ctrl #(
    parameter logic [7:0] RD_CMD      = 8'hEB,
    parameter logic [7:0] WR_CMD      = 8'h38,
    parameter int         DUMMY_CYC   = 7,
    parameter int         CE_HIGH_MIN = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        sck,
    output logic        ce_n,
    output logic [3:0]  dio_o,
    output logic [3:0]  dio_oe,
    input  logic [3:0]  dio_i
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_RESP  = 3'd5,
        ST_GAP   = 3'd6
    } state_t;

    // Last dummy period index and GAP lengths. After RESP the idle cycle that
    // accepts the next access is also high, so one GAP cycle less is needed.
    localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_CYC - 1);
    localparam logic [7:0] GAP_RESP   = 8'((CE_HIGH_MIN > 1) ? (CE_HIGH_MIN - 1) : 1);
    localparam logic [7:0] GAP_SPLIT  = 8'((CE_HIGH_MIN > 0) ? CE_HIGH_MIN : 1);

    state_t      state_q;
    logic        sck_q, ce_n_q, pready_q, pslverr_q, is_read_q;
    logic [3:0]  dio_o_q, dio_oe_q, cnt_q, nib_last_q, rem_q;
    logic [31:0] prdata_q, rbuf_q, wdata_q;
    logic [23:0] addr_q;
    logic [21:0] addr_hi_q;
    logic [7:0]  cmd_q, gap_cnt_q;
    logic [1:0]  s_q;

    logic [3:0]  mask_d, rem_d;
    logic [1:0]  s_d;
    logic [2:0]  len_d;

    // Byte-address bits outside the 24-bit word-aligned window are don't-care.
    logic unused_paddr;
    assign unused_paddr = ^{paddr[31:24], paddr[1:0]};

    // Index of the lowest set strobe bit.
    function automatic logic [1:0] lowest_bit(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Length of the run of ones starting at bit s.
    function automatic logic [2:0] run_len(input logic [3:0] m, input logic [1:0] s);
        logic [3:0] sh;
        sh = m >> s;
        casez (sh)
            4'b1111: return 3'd4;
            4'b?111: return 3'd3;
            4'b??11: return 3'd2;
            4'b???1: return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    // Strobe mask covering len lanes starting at lane s.
    function automatic logic [3:0] run_mask(input logic [1:0] s, input logic [2:0] len);
        logic [3:0] m;
        case (len)
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            3'd3:    m = 4'b0111;
            3'd4:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m << s;
    endfunction

    // Write nibble n of a frame starting at lane s: high nibble of each byte first.
    function automatic logic [3:0] wr_nibble(input logic [31:0] d, input logic [1:0] s,
                                             input logic [2:0] n);
        logic [1:0] lane;
        logic [7:0] b;
        lane = s + n[2:1];
        case (lane)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        return n[0] ? b[3:0] : b[7:4];
    endfunction

    // Address nibble k, most significant first.
    function automatic logic [3:0] addr_nib(input logic [23:0] a, input logic [3:0] k);
        case (k)
            4'd0:    return a[23:20];
            4'd1:    return a[19:16];
            4'd2:    return a[15:12];
            4'd3:    return a[11:8];
            4'd4:    return a[7:4];
            4'd5:    return a[3:0];
            default: return 4'h0;
        endcase
    endfunction

    // Decode the next contiguous byte run: from the APB strobe when idle,
    // from the leftover strobe between split frames.
    always_comb begin
        mask_d = (state_q == ST_GAP) ? rem_q : pstrb;
        s_d    = lowest_bit(mask_d);
        len_d  = run_len(mask_d, s_d);
        rem_d  = mask_d & ~run_mask(s_d, len_d);
    end

    // Controller FSM with all PSRAM and APB outputs registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sck_q      <= 1'b0;
            ce_n_q     <= 1'b1;
            dio_o_q    <= 4'h0;
            dio_oe_q   <= 4'h0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= 32'h0;
            rbuf_q     <= 32'h0;
            wdata_q    <= 32'h0;
            addr_q     <= 24'h0;
            addr_hi_q  <= 22'h0;
            cmd_q      <= 8'h0;
            gap_cnt_q  <= 8'h0;
            cnt_q      <= 4'h0;
            nib_last_q <= 4'h0;
            rem_q      <= 4'h0;
            s_q        <= 2'd0;
            is_read_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    if (psel && penable) begin
                        addr_hi_q <= paddr[23:2];
                        wdata_q   <= pwdata;
                        cnt_q     <= 4'h0;
                        if (!pwrite) begin
                            state_q    <= ST_CMD;
                            ce_n_q     <= 1'b0;
                            cmd_q      <= RD_CMD;
                            dio_o_q    <= {3'b000, RD_CMD[7]};
                            dio_oe_q   <= 4'b0001;
                            addr_q     <= {paddr[23:2], 2'b00};
                            is_read_q  <= 1'b1;
                            s_q        <= 2'd0;
                            nib_last_q <= 4'd7;
                            rem_q      <= 4'h0;
                        end else if (pstrb == 4'b0000) begin
                            state_q  <= ST_RESP;
                            pready_q <= 1'b1;
                        end else if (rem_d != 4'b0000) begin
`ifdef PSRAM_STRB_SPLIT_EN
                            state_q    <= ST_CMD;
                            ce_n_q     <= 1'b0;
                            cmd_q      <= WR_CMD;
                            dio_o_q    <= {3'b000, WR_CMD[7]};
                            dio_oe_q   <= 4'b0001;
                            addr_q     <= {paddr[23:2], s_d};
                            is_read_q  <= 1'b0;
                            s_q        <= s_d;
                            nib_last_q <= {len_d, 1'b0} - 4'd1;
                            rem_q      <= rem_d;
`else
                            state_q   <= ST_RESP;
                            pready_q  <= 1'b1;
                            pslverr_q <= 1'b1;
`endif
                        end else begin
                            state_q    <= ST_CMD;
                            ce_n_q     <= 1'b0;
                            cmd_q      <= WR_CMD;
                            dio_o_q    <= {3'b000, WR_CMD[7]};
                            dio_oe_q   <= 4'b0001;
                            addr_q     <= {paddr[23:2], s_d};
                            is_read_q  <= 1'b0;
                            s_q        <= s_d;
                            nib_last_q <= {len_d, 1'b0} - 4'd1;
                            rem_q      <= 4'h0;
                        end
                    end
                end
                ST_CMD: begin
                    if (!sck_q) begin
                        sck_q <= 1'b1;
                    end else begin
                        sck_q <= 1'b0;
                        if (cnt_q == 4'd7) begin
                            state_q  <= ST_ADDR;
                            cnt_q    <= 4'h0;
                            dio_o_q  <= addr_nib(addr_q, 4'd0);
                            dio_oe_q <= 4'hF;
                        end else begin
                            cnt_q   <= cnt_q + 4'd1;
                            dio_o_q <= {3'b000, cmd_q[3'd6 - cnt_q[2:0]]};
                        end
                    end
                end
                ST_ADDR: begin
                    if (!sck_q) begin
                        sck_q <= 1'b1;
                    end else begin
                        sck_q <= 1'b0;
                        if (cnt_q == 4'd5) begin
                            cnt_q <= 4'h0;
                            if (is_read_q) begin
                                state_q  <= ST_DUMMY;
                                dio_o_q  <= 4'h0;
                                dio_oe_q <= 4'h0;
                            end else begin
                                state_q  <= ST_DATA;
                                dio_o_q  <= wr_nibble(wdata_q, s_q, 3'd0);
                                dio_oe_q <= 4'hF;
                            end
                        end else begin
                            cnt_q   <= cnt_q + 4'd1;
                            dio_o_q <= addr_nib(addr_q, cnt_q + 4'd1);
                        end
                    end
                end
                ST_DUMMY: begin
                    if (!sck_q) begin
                        sck_q <= 1'b1;
                    end else begin
                        sck_q <= 1'b0;
                        if (cnt_q == DUMMY_LAST) begin
                            state_q <= ST_DATA;
                            cnt_q   <= 4'h0;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (!sck_q) begin
                        sck_q <= 1'b1;
                        if (is_read_q) begin
                            rbuf_q[{cnt_q[2:1], ~cnt_q[0], 2'b00} +: 4] <= dio_i;
                        end else begin
                            rbuf_q <= rbuf_q;
                        end
                    end else begin
                        sck_q <= 1'b0;
                        if (cnt_q == nib_last_q) begin
                            ce_n_q   <= 1'b1;
                            dio_o_q  <= 4'h0;
                            dio_oe_q <= 4'h0;
                            cnt_q    <= 4'h0;
                            if (rem_q != 4'b0000) begin
                                state_q   <= ST_GAP;
                                gap_cnt_q <= GAP_SPLIT;
                            end else begin
                                state_q   <= ST_RESP;
                                pready_q  <= 1'b1;
                                pslverr_q <= 1'b0;
                                if (is_read_q) begin
                                    prdata_q <= rbuf_q;
                                end else begin
                                    prdata_q <= prdata_q;
                                end
                            end
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                            if (is_read_q) begin
                                dio_o_q <= 4'h0;
                            end else begin
                                dio_o_q <= wr_nibble(wdata_q, s_q, cnt_q[2:0] + 3'd1);
                            end
                        end
                    end
                end
                ST_RESP: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    state_q   <= ST_GAP;
                    gap_cnt_q <= GAP_RESP;
                end
                ST_GAP: begin
                    if (gap_cnt_q <= 8'd1) begin
                        if (rem_q != 4'b0000) begin
                            state_q    <= ST_CMD;
                            ce_n_q     <= 1'b0;
                            cmd_q      <= WR_CMD;
                            dio_o_q    <= {3'b000, WR_CMD[7]};
                            dio_oe_q   <= 4'b0001;
                            addr_q     <= {addr_hi_q, s_d};
                            is_read_q  <= 1'b0;
                            s_q        <= s_d;
                            nib_last_q <= {len_d, 1'b0} - 4'd1;
                            rem_q      <= rem_d;
                            cnt_q      <= 4'h0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    sck_q    <= 1'b0;
                    ce_n_q   <= 1'b1;
                    dio_o_q  <= 4'h0;
                    dio_oe_q <= 4'h0;
                    pready_q <= 1'b0;
                end
            endcase
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign sck     = sck_q;
    assign ce_n    = ce_n_q;
    assign dio_o   = dio_o_q;
    assign dio_oe  = dio_oe_q;

endmodule

// File: tb/tb_psram_apb_ctrl.sv
// tb_psram_apb_ctrl: directed bench for psram_apb_ctrl with a small behavioural
// QPI PSRAM device (1 KiB) and a CE/sck frame monitor.
`timescale 1ns/1ps
module tb_psram_apb_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = 32'h0, pwdata = 32'h0;
    logic [3:0]  pstrb = 4'h0;
    logic [31:0] prdata;
    logic        pready, pslverr, sck, ce_n;
    logic [3:0]  dio_o, dio_oe;
    logic [3:0]  dio_i = 4'h0;

    psram_apb_ctrl dut (
        .clock(clock), .reset_n(reset_n), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .sck(sck),
        .ce_n(ce_n), .dio_o(dio_o), .dio_oe(dio_oe), .dio_i(dio_i)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    // ---------------- PSRAM device model ----------------
    logic [7:0]  mem [0:1023];
    int          k = 0;
    logic [7:0]  dcmd = 8'h0;
    logic [23:0] daddr = 24'h0;
    logic [3:0]  whi = 4'h0;
    logic [7:0]  last_cmd = 8'h0;
    logic [23:0] last_addr = 24'h0;
    int          last_k = 0;

    // Frame boundaries: ce_n edges restart the device and log the finished frame.
    always @(posedge ce_n or negedge ce_n) begin
        if (ce_n) begin
            last_cmd = dcmd; last_addr = daddr; last_k = k;
        end
        k = 0; dcmd = 8'h0; dio_i = 4'h0;
    end

    // Device samples command/address/write data on rising sck.
    always @(posedge sck) begin
        if (!ce_n) begin
            if (k < 8) dcmd = {dcmd[6:0], dio_o[0]};
            else if (k < 14) daddr = {daddr[19:0], dio_o};
            else if (dcmd == 8'h38) begin
                if (((k - 14) % 2) == 0) whi = dio_o;
                else mem[daddr[9:0] + 10'((k - 14) / 2)] = {whi, dio_o};
            end
            k++;
        end
    end

    // Device drives read nibbles on falling sck after the dummy periods.
    always @(negedge sck) begin
        logic [7:0] b;
        if (!ce_n && dcmd == 8'hEB && k >= 21 && k < 29) begin
            b = mem[daddr[9:0] + 10'((k - 21) / 2)];
            dio_i = (((k - 21) % 2) == 1) ? b[3:0] : b[7:4];
        end
    end

    // ---------------- frame monitor ----------------
    int   frames = 0, cur_low = 0, cur_high = 0, last_low = 0, last_high = 0, viol = 0;
    logic prev_ce = 1'b1;

    always @(negedge clock) begin
        if (ce_n !== prev_ce) begin
            if (ce_n) last_low = cur_low;
            else begin frames++; last_high = cur_high; end
            cur_low = 0; cur_high = 0;
        end
        if (ce_n) cur_high++; else cur_low++;
        if (ce_n && sck) viol++;
        prev_ce = ce_n;
    end

    // ---------------- APB master ----------------
    task automatic apb(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] st, input logic keep,
                       output int lat, output logic [31:0] rd, output logic err);
        lat = -1; rd = 32'h0; err = 1'b0;
        @(posedge clock); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = st;
        @(posedge clock); #1;
        penable = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (pready) begin lat = i; rd = prdata; err = pslverr; break; end
        end
        check_eq("apb_done", 32'(lat >= 0), 32'd1);
        @(posedge clock); #1;
        penable = 1'b0; psel = keep;
    endtask

    int          lat, f0;
    logic [31:0] rd;
    logic        err;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = init_val(i);

        // Reset state
        repeat (3) @(negedge clock);
        check_eq("reset_pins", {26'h0, sck, ce_n, dio_o}, 32'h10);
        check_eq("reset_oe_rsp", {26'h0, dio_oe, pready, pslverr}, 32'h0);
        check_eq("reset_prdata", prdata, 32'h0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // Full-word write
        apb(1'b1, 32'h104, 32'hDDCCBBAA, 4'hF, 1'b0, lat, rd, err);
        check_eq("wr4_lat", 32'(lat), 32'd45);
        check_eq("wr4_err", 32'(err), 32'd0);
        check_eq("wr4_bytes", {mem[263], mem[262], mem[261], mem[260]}, 32'hDDCCBBAA);
        check_eq("wr4_ce_low", 32'(last_low), 32'd44);
        check_eq("wr4_frame", {last_cmd, last_addr}, 32'h38000104);
        check_eq("wr4_periods", 32'(last_k), 32'd22);

        // Unaligned read is word-aligned
        apb(1'b0, 32'h106, 32'h0, 4'h0, 1'b0, lat, rd, err);
        check_eq("rd_lat", 32'(lat), 32'd59);
        check_eq("rd_data", rd, 32'hDDCCBBAA);
        check_eq("rd_frame", {last_cmd, last_addr}, 32'hEB000104);
        check_eq("rd_periods", 32'(last_k), 32'd29);
        check_eq("rd_ce_low", 32'(last_low), 32'd58);

        // Two middle lanes
        apb(1'b1, 32'h200, 32'h11223344, 4'b0110, 1'b0, lat, rd, err);
        check_eq("wr2_lat", 32'(lat), 32'd37);
        check_eq("wr2_frame", {last_cmd, last_addr}, 32'h38000201);
        check_eq("wr2_periods", 32'(last_k), 32'd18);
        check_eq("wr2_bytes", {mem[515], mem[514], mem[513], mem[512]},
                 {init_val(515), 8'h22, 8'h33, init_val(512)});

        // Non-contiguous strobe
        f0 = frames;
        apb(1'b1, 32'h300, 32'hA1B2C3D4, 4'b1001, 1'b0, lat, rd, err);
`ifdef PSRAM_STRB_SPLIT_EN
        check_eq("split_lat", 32'(lat), 32'd67);
        check_eq("split_err", 32'(err), 32'd0);
        check_eq("split_frames", 32'(frames - f0), 32'd2);
        check_eq("split_gap", 32'(last_high), 32'd2);
        check_eq("split_addr", {8'h0, last_addr}, 32'h303);
        check_eq("split_bytes", {mem[771], mem[770], mem[769], mem[768]},
                 {8'hA1, init_val(770), init_val(769), 8'hD4});
`else
        check_eq("nc_lat", 32'(lat), 32'd1);
        check_eq("nc_err", 32'(err), 32'd1);
        check_eq("nc_frames", 32'(frames - f0), 32'd0);
        check_eq("nc_bytes", {mem[771], mem[770], mem[769], mem[768]},
                 {init_val(771), init_val(770), init_val(769), init_val(768)});
`endif

        // Empty strobe
        repeat (4) @(negedge clock);
        f0 = frames;
        apb(1'b1, 32'h100, 32'hFFFFFFFF, 4'h0, 1'b0, lat, rd, err);
        check_eq("zs_lat", 32'(lat), 32'd1);
        check_eq("zs_err", 32'(err), 32'd0);
        check_eq("zs_frames", 32'(frames - f0), 32'd0);

        // Back-to-back reads with psel held
        repeat (4) @(negedge clock);
        apb(1'b0, 32'h200, 32'h0, 4'h0, 1'b1, lat, rd, err);
        check_eq("b2b_rd0", rd, {init_val(515), 8'h22, 8'h33, init_val(512)});
        apb(1'b0, 32'h104, 32'h0, 4'h0, 1'b0, lat, rd, err);
        check_eq("b2b_rd1", rd, 32'hDDCCBBAA);
        check_eq("b2b_lat1", 32'(lat), 32'd59);
        check_eq("b2b_gap_ok", 32'(last_high >= 2), 32'd1);

        // Reset in cycle 20 of a write
        repeat (4) @(negedge clock);
        @(posedge clock); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h180; pwdata = 32'h55667788; pstrb = 4'hF;
        @(posedge clock); #1;
        penable = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        check_eq("rst_pre", {30'h0, ce_n, sck}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_async", {26'h0, sck, ce_n, dio_oe}, 32'h10);
        check_eq("rst_pready", 32'(pready), 32'd0);
        psel = 1'b0; penable = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("rst_mem", {mem[387], mem[386], mem[385], mem[384]},
                 {init_val(387), init_val(386), init_val(385), init_val(384)});
        apb(1'b0, 32'h104, 32'h0, 4'h0, 1'b0, lat, rd, err);
        check_eq("rst_rd", rd, 32'hDDCCBBAA);
        check_eq("rst_rd_lat", 32'(lat), 32'd59);

        check_eq("sck_ce_rule", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
